wide_add_sequencer: RTL
=======================

Name: wide_add_sequencer

Overview:
- Multi-cycle wide integer adder/subtractor built around one instance of the team's 16-bit KoggeStone core (A, B, Cin -> S, Cout).
- Accepts full-width operands over a valid/ready handshake and streams them through the core one 16-bit chunk per cycle, LSB chunk first, chaining the carry in a register.
- Returns the full sum, carry-out and signed overflow on a second valid/ready handshake.
- Sits directly upstream of, and feeds, the 16-bit core; gives wide datapaths a single-slice adder instead of a W-bit carry tree.

Parameters:
- NCHUNK, 4, number of 16-bit chunks; operand width W = 16*NCHUNK. Legal range 2..16.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand request valid.
- in_ready  output  1  block can accept an operand request.
- in_a  input  W  operand A.
- in_b  input  W  operand B.
- in_cin  input  1  carry-in for add; ignored when in_sub=1.
- in_sub  input  1  1 = compute A - B (B inverted, carry-in forced 1).
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_sum  output  W  result.
- out_cout  output  1  carry-out of the MSB chunk (for subtract: 1 = no borrow).
- out_ovf  output  1  two's-complement signed overflow.

Behaviour:
- Reset (async, active-high):
  - All registers clear immediately: FSM=IDLE, chunk index=0, carry=0.
  - in_ready=0 while rst is high, 1 in the first cycle after release.
  - out_valid=0, out_sum=0, out_cout=0, out_ovf=0.
- FSM states IDLE, RUN, DONE.
- in_ready = (state==IDLE) | (state==DONE & out_ready).
- Accept = in_valid & in_ready.
  - Latches A, B' = in_sub ? ~in_b : in_b, and carry = in_sub ? 1 : in_cin.
  - Sets idx=0 and enters RUN.
- RUN, one chunk per cycle:
  - The core sees A[16*idx +: 16], B'[16*idx +: 16] and the carry register.
  - On the edge, core S is written into sum[16*idx +: 16], carry <= core Cout, idx <= idx+1.
  - When idx==NCHUNK-1, the edge also loads out_cout <= core Cout and out_ovf <= (A[W-1]==B'[W-1]) & (S[15]!=A[W-1]), then enters DONE.
- Latency: out_valid rises exactly NCHUNK cycles after the accept edge. Throughput is one operation per NCHUNK+1 cycles under no backpressure.
- DONE:
  - out_valid=1; out_sum, out_cout and out_ovf held stable until out_valid & out_ready.
  - On handshake without a new accept: go to IDLE, out_valid=0. out_sum, out_cout and out_ovf keep their values (don't-care when out_valid=0).
- Simultaneous result handshake and new accept in DONE: new operands latched, state goes straight to RUN, no bubble cycle.
- in_valid is ignored in RUN; in_ready=0 there.
- Operand inputs are sampled only on the accept edge; changes at other times have no effect.
- Partial sum bits are not visible as valid data before DONE.
- Reset asserted mid-RUN or in DONE: the operation is discarded, no out_valid is produced, and the block returns to the reset state.
- Wrap-around: the sum is modulo 2^W; carry beyond the MSB is reported only via out_cout.
- Core carry-in is the internal carry register only; no combinational path from in_* to out_*.

Test Plan:
- Reset (NCHUNK=4): assert rst mid-cycle -> all outputs 0 asynchronously; release -> in_ready=1 next cycle, out_valid=0.
- Full carry ripple:
  - Stimulus: A=0xFFFF_FFFF_FFFF_FFFF, B=0, cin=1, sub=0.
  - Required: out_valid exactly 4 cycles after accept; sum=0, cout=1, ovf=0.
- Subtract:
  - A=5, B=7, sub=1 -> sum=0xFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0.
  - A=7, B=5, sub=1 -> sum=2, cout=1, ovf=0.
- Signed overflow: A=0x7FFF_FFFF_FFFF_FFFF, B=1, add -> sum=0x8000_0000_0000_0000, ovf=1, cout=0. A=0x8000_0000_0000_0000, B=1, sub -> sum=0x7FFF_FFFF_FFFF_FFFF, ovf=1, cout=1.
- Backpressure and back-to-back:
  - Hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0.
  - Then out_ready=1 with in_valid=1 in the same cycle -> result consumed, new op accepted, next out_valid 4 cycles later.
  - 100 random back-to-back ops match a reference model.
- Reset mid-operation:
  - Assert rst two cycles after accept -> out_valid never asserts for that op.
  - After release, A=0x1234, B=0x1, add -> sum=0x1235, cout=0, ovf=0.

Source files
------------

// File: rtl/wide_add_sequencer.sv
// Multi-cycle wide adder/subtractor: streams W-bit operands through one 16-bit
// Kogge-Stone slice, LSB chunk first, with the carry chained in a register.

module kogge_stone_16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] s,
    output logic        cout
);
    // g[l]/p[l]: group generate/propagate after l prefix levels; cin is folded
    // into bit 0's generate so g[4][i] is the carry out of bit i.
    logic [15:0] g [0:4];
    logic [15:0] p [0:3];

    always_comb begin
        g[0]    = a & b;
        p[0]    = a ^ b;
        g[0][0] = (a[0] & b[0]) | ((a[0] ^ b[0]) & cin);
        for (int l = 0; l < 4; l++) begin
            g[l+1] = g[l];
            if (l < 3) p[l+1] = p[l];
            for (int i = 0; i < 16; i++) begin
                if (i >= (1 << l)) begin
                    g[l+1][i] = g[l][i] | (p[l][i] & g[l][i-(1<<l)]);
                    if (l < 3) p[l+1][i] = p[l][i] & p[l][i-(1<<l)];
                end
            end
        end
        s[0] = p[0][0] ^ cin;
        for (int i = 1; i < 16; i++) s[i] = p[0][i] ^ g[4][i-1];
        cout = g[4][15];
    end
endmodule

module wide_add_sequencer #(
    parameter int NCHUNK = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [16*NCHUNK-1:0] in_a,
    input  logic [16*NCHUNK-1:0] in_b,
    input  logic                 in_cin,
    input  logic                 in_sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [16*NCHUNK-1:0] out_sum,
    output logic                 out_cout,
    output logic                 out_ovf
);
    localparam int W  = 16 * NCHUNK;
    localparam int IW = $clog2(NCHUNK);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   idx;
    logic [W-1:0]    a_q, b_q, sum_q;
    logic            carry_q, cout_q, ovf_q;
    logic            accept, last;
    logic [15:0]     core_s;
    logic            core_cout;

    // Handshakes: a transfer happens on a rising edge where valid & ready are
    // both high; valid never depends on ready, and out_* hold while out_valid
    // is high and out_ready is low.
    assign accept = in_valid & in_ready;
    assign last   = (idx == IW'(NCHUNK - 1));

    kogge_stone_16 u_core (
        .a    (a_q[16*idx +: 16]),
        .b    (b_q[16*idx +: 16]),
        .cin  (carry_q),
        .s    (core_s),
        .cout (core_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = ~rst;
                if (in_valid & ~rst) state_nxt = RUN;
            end
            RUN: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = ~rst & out_ready;
                if (in_valid & out_ready) state_nxt = RUN;
                else if (out_ready)       state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            idx     <= '0;
        end else if (accept) begin
            a_q     <= in_a;
            b_q     <= in_sub ? ~in_b : in_b;
            carry_q <= in_sub | in_cin;
            idx     <= '0;
        end else if (state == RUN) begin
            sum_q[16*idx +: 16] <= core_s;
            carry_q             <= core_cout;
            if (last) begin
                idx    <= '0;
                cout_q <= core_cout;
                ovf_q  <= (a_q[W-1] == b_q[W-1]) & (core_s[15] != a_q[W-1]);
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

    assign out_sum  = sum_q;
    assign out_cout = cout_q;
    assign out_ovf  = ovf_q;
endmodule
